// File: rtl/fifo_flex.sv
// Single-clock parametrised FIFO: FWFT or registered read, programmable almost flags, occupancy, flush.
// Define FIFO_FLEX_ERR_EN to add the sticky ovf_err/udf_err outputs.
module fifo_flex #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 32,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [WIDTH-1:0]             enq_data,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [WIDTH-1:0]             deq_data,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FIFO_FLEX_ERR_EN
    ,
    output logic                         ovf_err,
    output logic                         udf_err
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

    if (DEPTH < 2 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
        $fatal(1, "fifo_flex: illegal parameters (need DEPTH>=2 and 0<=AE_THRESH<AF_THRESH<=DEPTH)");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic             w_do_enq;
    logic             w_do_deq;
    logic [PW-1:0]    w_wr_ptr_inc;
    logic [PW-1:0]    w_rd_ptr_inc;

    assign full         = (r_count == DEPTH_C);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);
    assign count        = r_count;

    // enq_ready deliberately ignores deq_ready: a full FIFO never accepts, even on a same-cycle pop.
    assign enq_ready = !full;
    assign deq_valid = !empty;

    assign w_do_enq = enq_valid && enq_ready;
    assign w_do_deq = deq_valid && deq_ready;

    // Explicit wrap so non-power-of-two depths work.
    assign w_wr_ptr_inc = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_inc = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_do_enq && !flush) begin
            r_mem[r_wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_enq) begin
                r_wr_ptr <= w_wr_ptr_inc;
            end
            if (w_do_deq) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            case ({w_do_enq, w_do_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign deq_data = r_mem[r_rd_ptr];
    end else begin : g_reg_read
        logic [WIDTH-1:0] r_deq_data;

        // Output register keeps the last popped word through flush.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_deq_data <= '0;
            end else if (w_do_deq && !flush) begin
                r_deq_data <= r_mem[r_rd_ptr];
            end
        end

        assign deq_data = r_deq_data;
    end

`ifdef FIFO_FLEX_ERR_EN
    logic r_ovf_err;
    logic r_udf_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else if (flush) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (enq_valid && full) begin
                r_ovf_err <= 1'b1;
            end
            if (deq_ready && empty) begin
                r_udf_err <= 1'b1;
            end
        end
    end

    assign ovf_err = r_ovf_err;
    assign udf_err = r_udf_err;
`endif

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised successor to the single-clock handshake FIFO, used for datapath buffering between producer and consumer stages.
- Adds a mode parameter that selects first-word-fall-through or registered-output read.
- Adds programmable almost-full and almost-empty flags, an occupancy output, and a synchronous flush.
- Supports any DEPTH >= 2, including non-power-of-two values.

Parameters:
DEPTH, 16, number of entries (>= 2, any integer)
WIDTH, 32, data width in bits
FWFT, 1, 1 = head word presented combinationally while non-empty; 0 = registered read, data one cycle after dequeue handshake
AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous clear of contents
enq_valid  in  1  producer has data
enq_ready  out  1  FIFO can accept (= !full)
enq_data  in  WIDTH  write data
deq_valid  out  1  FIFO has data (= !empty)
deq_ready  in  1  consumer accepts
deq_data  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Reset: rst high asynchronously clears wr_ptr, rd_ptr, count, and the deq_data register (FWFT=0) to 0.
  - After reset: empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH>0).
  - Memory contents are not reset.
- Handshakes:
  - do_enq = enq_valid && enq_ready.
  - do_deq = deq_valid && deq_ready.
  - enq_ready does not depend on deq_ready: no enqueue while full, even with a simultaneous dequeue.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) wide.
  - Each wraps to 0 after DEPTH-1, not by natural overflow.
- Count:
  - +1 on enqueue only; -1 on dequeue only.
  - Unchanged when neither or both occur.
- Flags are combinational from count only.
- FWFT=1:
  - deq_data = mem[rd_ptr] whenever deq_valid.
  - Write to an empty FIFO: deq_valid and data appear the cycle after do_enq. No same-cycle bypass.
  - deq_data is don't-care while empty.
- FWFT=0:
  - On do_deq, deq_data <= mem[rd_ptr]; valid from the next cycle.
  - Holds its value until the next do_deq.
- Flush (synchronous, rst low):
  - Pointers and count go to 0 on the next edge.
  - Overrides any enqueue or dequeue in the same cycle; neither takes effect.
  - FWFT=0: deq_data holds its value.
- Simultaneous enqueue and dequeue when not full and not empty: both pointers advance; count unchanged.
- Simultaneous enqueue and dequeue when empty: impossible, since deq_valid=0.
- Reset during traffic: all state clears immediately; in-flight handshakes are lost.
- Elaboration check: AE_THRESH < AF_THRESH <= DEPTH; fatal error otherwise.

Optional Feature:
- Macro FIFO_FLEX_ERR_EN.
- When defined, adds two sticky outputs, ovf_err and udf_err, each 1 bit and reset to 0:
  - ovf_err sets when enq_valid && full.
  - udf_err sets when deq_ready && empty && !flush.
  - Both clear only on rst or flush.
- When not defined: ports absent, no extra logic.

Test Plan:
- DEPTH=4, WIDTH=8, FWFT=1: enqueue 0x11, 0x22, 0x33, 0x44 with deq_ready=0 -> full=1, enq_ready=0, count=4, deq_data=0x11; then dequeue 4 -> 0x11, 0x22, 0x33, 0x44 in order, empty=1.
- FWFT=0: enqueue 0xA5, then dequeue -> deq_data=0xA5 on the cycle after the handshake and held until the next dequeue.
- DEPTH=5 wrap: 12 back-to-back enqueue+dequeue pairs at count=2 -> count stays 2, pointers wrap at 4 to 0, data order preserved.
- Flush with enq_valid=1 and deq_ready=1 at count=3 -> count=0, empty=1 next cycle; the flushed-cycle word is not stored.
- Thresholds DEPTH=8, AF=6, AE=2: fill 0 to 8 -> almost_empty drops at count=3, almost_full rises at count=6.
- Assert rst mid-burst at count=5 -> count=0, empty=1 immediately (asynchronous); with FIFO_FLEX_ERR_EN, enq_valid while full -> ovf_err=1 until flush.
